// File: rtl/axi_chan_buf.sv
// axi_chan_buf: elastic buffer for a single AXI channel (AW, W, B, AR or R).
// The channel payload travels as one packed vector.
//   MODE 0: combinational bypass.
//   MODE 1: 2-entry spill register. This is a full timing cut: there is no
//           combinational path from mst_ready_i to slv_ready_o.
//   MODE 2: DEPTH-entry circular FIFO with a registered output.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   flush_i                     synchronous flush, discards all held beats
//   slv_valid_i/ready_o/data_i  upstream handshake and payload
//   mst_valid_o/ready_i/data_o  downstream handshake and payload
//   fill_o                      number of beats currently held
//   stall_cnt_o                 cycles with mst_valid_o && !mst_ready_i,
//                               saturating (only with AXI_CHAN_BUF_STATS_EN)
// Optional feature macro: AXI_CHAN_BUF_STATS_EN
module axi_chan_buf #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MODE       = 1,
  parameter int unsigned CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  slv_valid_i,
  output logic                  slv_ready_o,
  input  logic [DATA_WIDTH-1:0] slv_data_i,
  output logic                  mst_valid_o,
  input  logic                  mst_ready_i,
  output logic [DATA_WIDTH-1:0] mst_data_o,
  output logic [CNT_W-1:0]      fill_o
`ifdef AXI_CHAN_BUF_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  if (MODE == 0) begin : g_bypass
    assign mst_valid_o = slv_valid_i;
    assign slv_ready_o = mst_ready_i;
    assign mst_data_o  = slv_data_i;
    assign fill_o      = '0;
  end else if (MODE == 1) begin : g_spill
    state_e                st_q, st_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  rdy_q, push, pop;

    assign push = slv_valid_i & rdy_q;
    assign pop  = (st_q != S_EMPTY) & mst_ready_i;

    always_comb begin
      st_d = st_q;
      a_d  = a_q;
      b_d  = b_q;
      if (flush_i) begin
        st_d = S_EMPTY;
      end else begin
        case (st_q)
          S_EMPTY: if (push) begin a_d = slv_data_i; st_d = S_ONE; end
          S_ONE: begin
            case ({push, pop})
              2'b11:   a_d = slv_data_i;
              2'b10:   begin b_d = slv_data_i; st_d = S_FULL; end
              2'b01:   st_d = S_EMPTY;
              default: ;
            endcase
          end
          // In FULL, rdy_q is 0, so no push can happen here.
          S_FULL:  if (pop) begin a_d = b_q; st_d = S_ONE; end
          default: st_d = S_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q  <= S_EMPTY;
        a_q   <= '0;
        b_q   <= '0;
        rdy_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        a_q   <= a_d;
        b_q   <= b_d;
        // ready is registered from the next state: it means "B will be free".
        rdy_q <= (st_d != S_FULL);
      end
    end

    assign slv_ready_o = rdy_q;
    assign mst_valid_o = (st_q != S_EMPTY);
    assign mst_data_o  = a_q;
    assign fill_o      = (st_q == S_FULL) ? CNT_W'(2) :
                         (st_q == S_ONE)  ? CNT_W'(1) : '0;
  end else begin : g_fifo
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, rest;
    logic                  rdy_q, push, pop;

    assign push = slv_valid_i & rdy_q;
    assign pop  = (cnt_q != '0) & mst_ready_i;
    // Beats still held after this cycle's pop, not counting this cycle's push.
    assign rest = cnt_q - CNT_W'(pop);

    always_comb begin
      rptr_d = rptr_q + PW'(pop);
      wptr_d = wptr_q + PW'(push);
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
      out_d  = out_q;
      if (flush_i) begin
        rptr_d = '0;
        wptr_d = '0;
        cnt_d  = '0;
      end else if (rest == '0) begin
        // The FIFO drains to empty, so an incoming beat goes straight to the
        // output register.
        if (push) out_d = slv_data_i;
      end else begin
        // The new head was written in an earlier cycle and is already in mem.
        out_d = mem_q[rptr_d];
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= slv_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
        out_q  <= '0;
        rdy_q  <= 1'b0;
      end else begin
        rptr_q <= rptr_d;
        wptr_q <= wptr_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        rdy_q  <= (cnt_d != CNT_W'(DEPTH));
      end
    end

    assign slv_ready_o = rdy_q;
    assign mst_valid_o = (cnt_q != '0);
    assign mst_data_o  = out_q;
    assign fill_o      = cnt_q;
  end

`ifdef AXI_CHAN_BUF_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                               stall_q <= '0;
    else if (flush_i)                                          stall_q <= '0;
    else if (mst_valid_o && !mst_ready_i && (stall_q != '1))   stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_axi_chan_buf.sv
// Bench for axi_chan_buf. It runs one instance per mode (bypass, spill, 4-deep FIFO)
// against a queue-based reference model, plus directed literal checks.
module tb_axi_chan_buf;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sv[3], mr[3], fl[3];
  logic [7:0] sd[3];
  logic       srdy[3], mv[3];
  logic [7:0] md[3];
  logic [2:0] fill[3];
`ifdef AXI_CHAN_BUF_STATS_EN
  logic [31:0] scnt[3];
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_chan_buf #(.DATA_WIDTH(8), .DEPTH(4), .MODE(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]),
    .slv_valid_i(sv[0]), .slv_ready_o(srdy[0]), .slv_data_i(sd[0]),
    .mst_valid_o(mv[0]), .mst_ready_i(mr[0]), .mst_data_o(md[0]), .fill_o(fill[0])
`ifdef AXI_CHAN_BUF_STATS_EN
    , .stall_cnt_o(scnt[0])
`endif
  );
  axi_chan_buf #(.DATA_WIDTH(8), .DEPTH(4), .MODE(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]),
    .slv_valid_i(sv[1]), .slv_ready_o(srdy[1]), .slv_data_i(sd[1]),
    .mst_valid_o(mv[1]), .mst_ready_i(mr[1]), .mst_data_o(md[1]), .fill_o(fill[1])
`ifdef AXI_CHAN_BUF_STATS_EN
    , .stall_cnt_o(scnt[1])
`endif
  );
  axi_chan_buf #(.DATA_WIDTH(8), .DEPTH(4), .MODE(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]),
    .slv_valid_i(sv[2]), .slv_ready_o(srdy[2]), .slv_data_i(sd[2]),
    .mst_valid_o(mv[2]), .mst_ready_i(mr[2]), .mst_data_o(md[2]), .fill_o(fill[2])
`ifdef AXI_CHAN_BUF_STATS_EN
    , .stall_cnt_o(scnt[2])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held beats with a capacity limit.
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  bit          started = 1'b0;
  logic [31:0] mstall[3];

  function automatic int msize(input int k);
    if (k == 1) return q1.size();
    if (k == 2) return q2.size();
    return 0;
  endfunction

  function automatic logic mvalid(input int k);
    if (k == 0) return sv[0];
    return msize(k) > 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      started = 1'b0;
      for (int k = 0; k < 3; k++) mstall[k] = '0;
    end else begin
      bit acc, drn;
      for (int k = 0; k < 3; k++) begin
        if (fl[k]) mstall[k] = '0;
        else if (mvalid(k) && !mr[k] && mstall[k] != 32'hFFFF_FFFF) mstall[k] = mstall[k] + 1;
      end
      acc = sv[1] && started && q1.size() < 2;
      drn = q1.size() > 0 && mr[1];
      if (fl[1]) q1.delete();
      else begin
        if (drn) void'(q1.pop_front());
        if (acc) q1.push_back(sd[1]);
      end
      acc = sv[2] && started && q2.size() < 4;
      drn = q2.size() > 0 && mr[2];
      if (fl[2]) q2.delete();
      else begin
        if (drn) void'(q2.pop_front());
        if (acc) q2.push_back(sd[2]);
      end
      started = 1'b1;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m0_valid", 32'(mv[0]), 32'(sv[0]));
      chk("m0_ready", 32'(srdy[0]), 32'(mr[0]));
      chk("m0_data", 32'(md[0]), 32'(sd[0]));
      chk("m0_fill", 32'(fill[0]), 32'd0);
      for (int k = 1; k < 3; k++) begin
        chk($sformatf("m%0d_valid", k), 32'(mv[k]), 32'(msize(k) > 0));
        chk($sformatf("m%0d_fill", k), 32'(fill[k]), 32'(msize(k)));
        chk($sformatf("m%0d_ready", k), 32'(srdy[k]),
            32'(started && msize(k) < (k == 1 ? 2 : 4)));
        if (msize(k) > 0)
          chk($sformatf("m%0d_data", k), 32'(md[k]), 32'(k == 1 ? q1[0] : q2[0]));
      end
`ifdef AXI_CHAN_BUF_STATS_EN
      for (int k = 0; k < 3; k++) chk($sformatf("m%0d_stall", k), scnt[k], mstall[k]);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0; mr[k] = 1'b0; fl[k] = 1'b0; sd[k] = '0;
    end
    mr[0] = 1'b1;
    #2;
    chk("rst_rdy1", 32'(srdy[1]), 0);
    chk("rst_rdy2", 32'(srdy[2]), 0);
    chk("rst_vld1", 32'(mv[1]), 0);
    chk("rst_vld2", 32'(mv[2]), 0);
    chk("rst_fill2", 32'(fill[2]), 0);
    chk("rst_data1", 32'(md[1]), 0);
    chk("rst_data2", 32'(md[2]), 0);
    chk("rst_rdy0", 32'(srdy[0]), 1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy1", 32'(srdy[1]), 1);
    chk("post_rst_rdy2", 32'(srdy[2]), 1);

    // MODE 1 with an always-ready sink: one cycle of latency, order kept.
    mr[1] = 1; sv[1] = 1; sd[1] = 8'h11; step();
    chk("sp_d11", 32'(md[1]), 32'h11); chk("sp_f1a", 32'(fill[1]), 1);
    sd[1] = 8'h22; step();
    chk("sp_d22", 32'(md[1]), 32'h22); chk("sp_r1", 32'(srdy[1]), 1);
    sd[1] = 8'h33; step();
    chk("sp_d33", 32'(md[1]), 32'h33); chk("sp_f1b", 32'(fill[1]), 1);
    sv[1] = 0; step();
    chk("sp_empty", 32'(mv[1]), 0);

    // MODE 1 with a stalled sink: the spill register fills, then drains.
    mr[1] = 0; sv[1] = 1; sd[1] = 8'h0A; step();
    sd[1] = 8'h0B; step();
    chk("sp_full_f", 32'(fill[1]), 2); chk("sp_full_r", 32'(srdy[1]), 0);
    chk("sp_full_d", 32'(md[1]), 32'h0A);
    sv[1] = 0; mr[1] = 1; step();
    chk("sp_dB", 32'(md[1]), 32'h0B); chk("sp_f1c", 32'(fill[1]), 1);
    step();
    chk("sp_f0", 32'(fill[1]), 0);
    // MODE 1 flush.
    mr[1] = 0; sv[1] = 1; sd[1] = 8'h77; step();
    sv[1] = 0; fl[1] = 1; step();
    fl[1] = 0;
    chk("sp_fl_v", 32'(mv[1]), 0); chk("sp_fl_f", 32'(fill[1]), 0);

    // MODE 2 with a stalled sink: 4 of 5 beats accepted.
    mr[2] = 0;
    for (int i = 1; i <= 5; i++) begin
      sv[2] = 1; sd[2] = 8'(i); step();
    end
    chk("ff_f4", 32'(fill[2]), 4); chk("ff_r0", 32'(srdy[2]), 0);
    chk("ff_d1", 32'(md[2]), 1);
    mr[2] = 1; step();
    chk("ff_d2", 32'(md[2]), 2); chk("ff_f3", 32'(fill[2]), 3);
    step();
    chk("ff_d3", 32'(md[2]), 3); chk("ff_f3b", 32'(fill[2]), 3);
    sv[2] = 0; step(); step();
    chk("ff_d5", 32'(md[2]), 5);
    step();
    chk("ff_f0", 32'(fill[2]), 0);

    // MODE 2 back-to-back traffic: the pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      sv[2] = 1; sd[2] = 8'(8'h20 + i); step();
      chk("ff_bb_d", 32'(md[2]), 32'(8'h20 + i)); chk("ff_bb_f", 32'(fill[2]), 1);
    end
    sv[2] = 0; step();
    chk("ff_bb_f0", 32'(fill[2]), 0);

    // MODE 2 flush while holding 3 beats; the beat presented during the flush is dropped.
    mr[2] = 0;
    for (int i = 0; i < 3; i++) begin
      sv[2] = 1; sd[2] = 8'(8'h31 + i); step();
    end
    chk("ff_h3", 32'(fill[2]), 3); chk("ff_h3r", 32'(srdy[2]), 1);
    fl[2] = 1; sd[2] = 8'h44; step();
    fl[2] = 0; sv[2] = 0;
    chk("ff_fl_v", 32'(mv[2]), 0); chk("ff_fl_f", 32'(fill[2]), 0);
    mr[2] = 1; step();
    chk("ff_fl_drop", 32'(fill[2]), 0);

    // MODE 0: ready mirrors the sink in the same cycle; 7 stalled cycles.
    sv[0] = 1; sd[0] = 8'h5A; mr[0] = 1; #1;
    chk("by_r1", 32'(srdy[0]), 1); chk("by_d", 32'(md[0]), 32'h5A);
    mr[0] = 0; #1;
    chk("by_r0", 32'(srdy[0]), 0); chk("by_v", 32'(mv[0]), 1);
    for (int i = 0; i < 7; i++) step();
`ifdef AXI_CHAN_BUF_STATS_EN
    chk("by_stall7", scnt[0], 32'd7);
`endif
    sv[0] = 0; mr[0] = 1; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
